// File: rtl/plb_single_master.sv
// plb_single_master
//   Single-beat PLB v4.6 master. A valid/ready command port is turned into
//   one PLB read or write transaction at a time. The read data and the error
//   status come back on a valid/ready response port. There is no burst
//   support and no more than one transaction is outstanding.
//
// Ports
//   MPLB_Clk, MPLB_Rst        clock; synchronous active-low reset
//   cmd_*                     command in (valid/ready, rnw, addr, wdata, be)
//   rsp_*                     response out (valid/ready, rdata, err)
//   M_*                       PLB master request/address/write-data outputs
//   PLB_M*                    PLB master-side replies from the arbiter/slave
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | cmd_ready high; waiting for a command
// REQ     | M_request high; address phase in progress
// BACKOFF | one dead cycle after rearbitrate; M_request low
// WDATA   | address acked; waiting for the write data ack or the timer
// RDATA   | address acked; waiting for the read data ack or the timer
// RESP    | rsp_valid high; waiting for rsp_ready
module plb_single_master #(
    parameter int          C_MPLB_AWIDTH        = 32,
    parameter int          C_MPLB_DWIDTH        = 32,
    parameter int          C_MPLB_NATIVE_DWIDTH = 32,
    parameter logic [1:0]  C_PRIORITY           = 2'b00,
    parameter int          C_DPHASE_TIMEOUT     = 64,
    parameter string       C_FAMILY             = "spartan6"
) (
    input  logic                       MPLB_Clk,
    input  logic                       MPLB_Rst,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_rnw,
    input  logic [0:C_MPLB_AWIDTH-1]   cmd_addr,
    input  logic [0:C_MPLB_DWIDTH-1]   cmd_wdata,
    input  logic [0:3]                 cmd_be,

    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [0:C_MPLB_DWIDTH-1]   rsp_rdata,
    output logic                       rsp_err,

    output logic                       M_request,
    output logic                       M_busLock,
    output logic                       M_RNW,
    output logic                       M_abort,
    output logic                       M_lockErr,
    output logic                       M_wrBurst,
    output logic                       M_rdBurst,
    output logic [0:1]                 M_priority,
    output logic [0:1]                 M_MSize,
    output logic [0:3]                 M_size,
    output logic [0:2]                 M_type,
    output logic [0:3]                 M_BE,
    output logic [0:15]                M_TAttribute,
    output logic [0:C_MPLB_AWIDTH-1]   M_ABus,
    output logic [0:31]                M_UABus,
    output logic [0:C_MPLB_DWIDTH-1]   M_wrDBus,

    input  logic                       PLB_MAddrAck,
    input  logic                       PLB_MRearbitrate,
    input  logic                       PLB_MTimeout,
    input  logic                       PLB_MRdDAck,
    input  logic                       PLB_MWrDAck,
    input  logic                       PLB_MRdBTerm,
    input  logic                       PLB_MWrBTerm,
    input  logic                       PLB_MBusy,
    input  logic                       PLB_MRdErr,
    input  logic                       PLB_MWrErr,
    input  logic                       PLB_MIRQ,
    input  logic [0:1]                 PLB_MSSize,
    input  logic [0:3]                 PLB_MRdWdAddr,
    input  logic [0:C_MPLB_DWIDTH-1]   PLB_MRdDBus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        BACKOFF = 3'd2,
        WDATA   = 3'd3,
        RDATA   = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam logic [7:0] DTMO_LAST = 8'(C_DPHASE_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] dcnt;
    logic       err_nxt;
    logic       wr_acked;
    logic       dtmo;

    assign M_busLock    = 1'b0;
    assign M_abort      = 1'b0;
    assign M_lockErr    = 1'b0;
    assign M_wrBurst    = 1'b0;
    assign M_rdBurst    = 1'b0;
    assign M_priority   = C_PRIORITY;
    assign M_MSize      = 2'b00;
    assign M_size       = 4'b0000;
    assign M_type       = 3'b000;
    assign M_TAttribute = '0;
    assign M_UABus      = '0;

    assign cmd_ready = (state == IDLE);
    assign M_request = (state == REQ);

    // The timer counts data-phase cycles; the terminal count ends the phase
    // on the C_DPHASE_TIMEOUT-th cycle without a data ack.
    assign dtmo = (dcnt == DTMO_LAST);

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        wr_acked  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = REQ;
            end
            REQ: begin
                // addrAck takes priority over a same-cycle bus timeout.
                if (PLB_MAddrAck) begin
                    if (M_RNW) begin
                        state_nxt = RDATA;
                    end else if (PLB_MWrDAck) begin
                        state_nxt = RESP;
                        err_nxt   = PLB_MWrErr;
                        wr_acked  = 1'b1;
                    end else begin
                        state_nxt = WDATA;
                    end
                end else if (PLB_MRearbitrate) begin
                    state_nxt = BACKOFF;
                end else if (PLB_MTimeout) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b1;
                end
            end
            BACKOFF: begin
                state_nxt = REQ;
            end
            WDATA: begin
                if (PLB_MWrDAck) begin
                    state_nxt = RESP;
                    err_nxt   = PLB_MWrErr;
                    wr_acked  = 1'b1;
                end else if (dtmo) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b1;
                end
            end
            RDATA: begin
                if (PLB_MRdDAck) begin
                    state_nxt = RESP;
                    err_nxt   = PLB_MRdErr;
                end else if (dtmo) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge MPLB_Clk) begin
        if (!MPLB_Rst) begin
            state     <= IDLE;
            dcnt      <= '0;
            M_ABus    <= '0;
            M_BE      <= '0;
            M_RNW     <= 1'b0;
            M_wrDBus  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nxt;

            // Both data phases are entered only from REQ, so clearing there
            // is the same as clearing on entry.
            if (state == REQ) begin
                dcnt <= '0;
            end else if (state == WDATA || state == RDATA) begin
                dcnt <= dcnt + 8'd1;
            end

            if (state == IDLE && cmd_valid) begin
                M_RNW     <= cmd_rnw;
                M_ABus    <= {cmd_addr[0:C_MPLB_AWIDTH-3], 2'b00};
                M_BE      <= cmd_be;
                M_wrDBus  <= cmd_rnw ? '0 : cmd_wdata;
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end

            if (wr_acked) M_wrDBus <= '0;

            if (state == RDATA && PLB_MRdDAck) rsp_rdata <= PLB_MRdDBus;

            if (state == RESP) begin
                if (rsp_ready) rsp_valid <= 1'b0;
            end else if (state_nxt == RESP) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err_nxt;
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{PLB_MSSize, PLB_MRdWdAddr, PLB_MRdBTerm, PLB_MWrBTerm,
                             PLB_MBusy, PLB_MIRQ,
                             cmd_addr[C_MPLB_AWIDTH-2:C_MPLB_AWIDTH-1],
                             (C_MPLB_NATIVE_DWIDTH != 32), (C_FAMILY != "")};

endmodule

// File: doc/plb_single_master.md
# plb_single_master

Single-beat PLB v4.6 master that turns a simple valid/ready command port into PLB read or write transactions and returns read data and error status on a response port. It is the initiator counterpart to our PLB slave peripherals such as the muxed-display core. It sits between local logic (DMA-lite, self-test sequencer) and the system PLB master port. It has no burst support and at most one transaction outstanding.

## Interface
- C_MPLB_AWIDTH, 32, address width
- C_MPLB_DWIDTH, 32, PLB data bus width (32 only)
- C_MPLB_NATIVE_DWIDTH, 32, native width; M_MSize = 2'b00
- C_PRIORITY, 2'b00, value driven on M_priority
- C_DPHASE_TIMEOUT, 64, data-phase timeout in cycles (>= 4)
- C_FAMILY, "spartan6", target family, informational only

Ports:
- MPLB_Clk  in  1  clock
- MPLB_Rst  in  1  **one clock; reset is synchronous and active-low**
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_rnw  in  1  1 = read, 0 = write
- cmd_addr  in  [0:31]  word address; bits 30:31 are ignored and driven as 0
- cmd_wdata  in  [0:31]  write data
- cmd_be  in  [0:3]  byte enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  [0:31]  read data (0 for writes)
- rsp_err  out  1  slave error, address timeout or data-phase timeout
- M_request, M_busLock, M_RNW, M_abort, M_lockErr, M_wrBurst, M_rdBurst  out  1 each
- M_priority  out  [0:1];  M_MSize  out  [0:1];  M_size  out  [0:3];  M_type  out  [0:2]
- M_BE  out  [0:3];  M_TAttribute  out  [0:15];  M_ABus, M_UABus, M_wrDBus  out  [0:31]
- PLB_MAddrAck, PLB_MRearbitrate, PLB_MTimeout, PLB_MRdDAck, PLB_MWrDAck, PLB_MRdBTerm, PLB_MWrBTerm, PLB_MBusy, PLB_MRdErr, PLB_MWrErr, PLB_MIRQ  in  1 each
- PLB_MSSize  in  [0:1];  PLB_MRdWdAddr  in  [0:3];  PLB_MRdDBus  in  [0:31]

## Operation
- Constant outputs: M_busLock, M_abort, M_lockErr, M_wrBurst, M_rdBurst = 0. M_size = 0000, M_type = 000, M_TAttribute = 0, M_UABus = 0, M_MSize = 00, M_priority = C_PRIORITY.
- FSM states: IDLE, REQ, BACKOFF, WDATA, RDATA, RESP.
- IDLE: cmd_ready = 1. On cmd_valid, register rnw, addr, be and wdata, then go to REQ. No command is accepted in any other state.
- REQ: M_request = 1. M_ABus, M_BE and M_RNW are driven from the registers. For writes, M_wrDBus is held valid from REQ until the write data acknowledge.
  - PLB_MAddrAck + read → RDATA.
  - PLB_MAddrAck + write + PLB_MWrDAck in the same cycle → RESP, with err = PLB_MWrErr.
  - PLB_MAddrAck + write → WDATA.
  - PLB_MRearbitrate (no addrAck) → BACKOFF.
  - PLB_MTimeout → RESP, with err = 1.
- BACKOFF: M_request = 0 for exactly one cycle, then REQ.
- WDATA: PLB_MWrDAck → RESP, with err = PLB_MWrErr.
- RDATA: PLB_MRdDAck → capture PLB_MRdDBus into rsp_rdata, go to RESP, with err = PLB_MRdErr.
- Data-phase timer: 8-bit counter, cleared on entry to WDATA or RDATA. Reaching C_DPHASE_TIMEOUT → RESP, with err = 1 and rdata = 0.
- RESP: rsp_valid = 1 and the outputs are held stable. rsp_valid·rsp_ready → IDLE.
- PLB_MSSize, PLB_MRdWdAddr, BTerm, PLB_MBusy and PLB_MIRQ are ignored.

## Timing
- All outputs are registered except cmd_ready and M_request, which are decoded from state.
- Reset (MPLB_Rst = 0 at a rising edge): state = IDLE.
  - M_request = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - M_ABus = 0, M_BE = 0, M_RNW = 0, M_wrDBus = 0.
  - cmd_ready = 1 from the first cycle after reset is released.
- Reset mid-transaction abandons the transaction with no response.
- Minimum latency from cmd accept to rsp_valid:
  - write with same-cycle addrAck and wrDAck: 2 cycles;
  - read with addrAck on the first REQ cycle and rdDAck on the next cycle: 3 cycles.
- Back-to-back: a rsp_ready handshake returns the FSM to IDLE, so the next command is accepted one cycle later.
- M_request deasserts in the cycle after PLB_MAddrAck is sampled. It is never asserted on two consecutive cycles across a rearbitrate.
- If PLB_MTimeout and PLB_MAddrAck are sampled in the same cycle, addrAck wins.

## Test plan
- Write A = 0xC3C00004, D = 0x0000_1234, BE = 1111; slave gives addrAck and wrDAck 2 cycles after request → M_wrDBus = 0x00001234 through the dack cycle; rsp_valid with err = 0; cmd_ready low until rsp_ready.
- Read A = 0xC3C00008; slave returns 0xDEADBEEF on rdDAck 3 cycles after addrAck → rsp_rdata = 0xDEADBEEF, err = 0; M_RNW = 1 during REQ.
- Rearbitrate twice, then addrAck → M_request pattern 1, 0, 1, 0, 1; exactly one transaction is completed.
- No addrAck, PLB_MTimeout pulses → rsp_err = 1, rsp_rdata = 0; the next command proceeds normally.
- addrAck with no rdDAck for 64 cycles → rsp_err = 1 at cycle 64; a late rdDAck arriving in IDLE is ignored.
- Assert MPLB_Rst = 0 during WDATA → all outputs at reset values on the next cycle; a new write then completes cleanly.
